// File: rtl/serial_adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM state
// encodings and a ceiling-log2 helper usable in parameter expressions.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r such that 2**r >= n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit adder slice: sum, carry-out and the carry that
// enters the top bit of the digit (needed for signed overflow detection).
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] total;

  // One DIGIT+1 bit add covers the full-adder chain; the top bit is the carry.
  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    s     = total[DIGIT-1:0];
    co    = total[DIGIT];
    // The top sum bit is x^y^carry_in at that bit, so the carry in is recoverable.
    c_msb = total[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in DIGIT bits per
// clock, chaining digits through one carry flip-flop. Results are held from
// the completion edge until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = clog2(NDIG) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [DIGIT-1:0] d_sum;
  logic             d_co;
  logic             d_msb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_sh[DIGIT-1:0]),
    .y     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .s     (d_sum),
    .co    (d_co),
    .c_msb (d_msb)
  );

  // Start is only honoured when the previous operation has finished.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // New digit enters at the MSB end; after NDIG shifts acc holds the full sum.
  assign acc_next = WIDTH'({d_sum, acc} >> DIGIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: DONE lasts one cycle unless a new start chains straight on.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, per-digit accumulation and result registering on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= d_co;
      cnt   <= cnt + CW'(1);
      acc   <= acc_next;
      if (last) begin
        sum   <= acc_next;
        c_out <= d_co;
        ovf   <= d_msb ^ d_co;
      end
    end
  end

endmodule
